// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles (multi-cycle),
// data-memory wait freezes, taken-branch IF/ID flushes and a saturating stall counter.
module hazard_stall_controller #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0]  IDEX_RegisterRt,
  input  logic [REG_ADDR_W-1:0]  IFID_RegisterRs,
  input  logic [REG_ADDR_W-1:0]  IFID_RegisterRt,
  input  logic                   IFID_UsesRt,
  input  logic                   Branch_Taken,
  input  logic                   DMem_Req,
  input  logic                   DMem_Ready,
  input  logic                   Stall_Count_Clr,
  output logic                   PC_Write,
  output logic                   IFID_Write,
  output logic                   Control_select,
  output logic                   IFID_Flush,
  output logic                   Pipe_Freeze,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_LS  = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [3:0]             rem_q, rem_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hz, memwait;
  logic                   pc_w, cs, fl, fz;

  assign hz = IDEX_MemRead && (IDEX_RegisterRt != '0) &&
              ((IDEX_RegisterRt == IFID_RegisterRs) ||
               (IFID_UsesRt && (IDEX_RegisterRt == IFID_RegisterRt)));
  assign memwait = DMem_Req && !DMem_Ready;

  always_comb begin
    pc_w    = 1'b1;
    cs      = 1'b0;
    fl      = 1'b0;
    fz      = 1'b0;
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_RUN: begin
        if (memwait) begin
          fz      = 1'b1;
          pc_w    = 1'b0;
          state_d = S_MW;
        end else if (hz) begin
          pc_w = 1'b0;
          cs   = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            rem_d   = REM_INIT;
            state_d = S_LS;
          end
        end else if (Branch_Taken) begin
          fl = 1'b1;
        end
      end
      S_LS: begin
        pc_w = 1'b0;
        if (memwait) begin
          // rem is preserved so the remaining bubbles resume after the wait
          fz      = 1'b1;
          state_d = S_MW;
        end else begin
          cs = 1'b1;
          if (rem_q <= 4'd1) begin
            rem_d   = 4'd0;
            state_d = S_RUN;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      S_MW: begin
        pc_w = 1'b0;
        fz   = 1'b1;
        if (DMem_Ready) state_d = (rem_q != 4'd0) ? S_LS : S_RUN;
      end
      default: begin
        state_d = S_RUN;
        rem_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Stall_Count_Clr)              cnt_d = '0;
    else if (!pc_w && cnt_q != '1)    cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      rem_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their defaults while reset is asserted, independent of inputs.
  assign PC_Write       = pc_w | ~rst_n;
  assign IFID_Write     = pc_w | ~rst_n;
  assign Control_select = cs & rst_n;
  assign IFID_Flush     = fl & rst_n;
  assign Pipe_Freeze    = fz & rst_n;
  assign Stall_Count    = cnt_q;

endmodule
